// File: rtl/chime_sequencer.sv
// Two-tone doorbell chime: a rising edge on button plays DING, a silent GAP, then DONG,
// and pulses done on return to IDLE. All outputs come straight from flops.
module chime_sequencer #(
    parameter logic [15:0] TONE_LEN = 16'd1000,
    parameter logic [15:0] GAP_LEN  = 16'd200,
    parameter logic [15:0] A_HALF   = 16'd10,
    parameter logic [15:0] B_HALF   = 16'd13
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic a,
    output logic b,
    output logic sel,
    output logic play,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {IDLE, DING, GAP, DONG} state_t;

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] tone_q, tone_d;
    logic        button_q;
    logic        start;
    logic        a_q, a_d, b_q, b_d;
    logic        sel_q, sel_d, play_q, play_d, busy_q, busy_d, done_q, done_d;

    assign start = button & ~button_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= 16'd0;
            tone_q   <= 16'd0;
            button_q <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            sel_q    <= 1'b0;
            play_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tone_q   <= tone_d;
            button_q <= button;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            play_q   <= play_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // phase_q counts down the cycles left in the current phase; tone_q counts down to the next toggle
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tone_d  = tone_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DING;
                    phase_d = TONE_LEN - 16'd1;
                    tone_d  = A_HALF - 16'd1;
                end
            end
            DING: begin
                if (phase_q == 16'd0) begin
                    state_d = GAP;
                    phase_d = GAP_LEN - 16'd1;
                end else begin
                    phase_d = phase_q - 16'd1;
                    if (tone_q == 16'd0) begin
                        a_d    = ~a_q;
                        tone_d = A_HALF - 16'd1;
                    end else begin
                        a_d    = a_q;
                        tone_d = tone_q - 16'd1;
                    end
                end
            end
            GAP: begin
                if (phase_q == 16'd0) begin
                    state_d = DONG;
                    phase_d = TONE_LEN - 16'd1;
                    tone_d  = B_HALF - 16'd1;
                end else begin
                    phase_d = phase_q - 16'd1;
                end
            end
            DONG: begin
                if (phase_q == 16'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q - 16'd1;
                    if (tone_q == 16'd0) begin
                        b_d    = ~b_q;
                        tone_d = B_HALF - 16'd1;
                    end else begin
                        b_d    = b_q;
                        tone_d = tone_q - 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        sel_d  = (state_d == DONG);
        play_d = (state_d == DING) || (state_d == DONG);
        busy_d = (state_d != IDLE);
    end

    assign a    = a_q;
    assign b    = b_q;
    assign sel  = sel_q;
    assign play = play_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Bench for chime_sequencer with TONE_LEN=8, GAP_LEN=4, A_HALF=2, B_HALF=3:
// per-cycle expected outputs are queued as stimulus is driven and checked after each edge.
module tb_chime_sequencer;

    typedef struct packed {
        logic busy;
        logic play;
        logic sel;
        logic a;
        logic b;
        logic done;
    } outs_t;

    typedef struct {
        logic  button;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic button = 1'b0;
    logic a, b, sel, play, busy, done;

    int checks = 0;
    int errors = 0;

    outs_t exp_q[$];
    string name_q[$];
    vec_t  tbl[24];

    localparam outs_t IDLE_O = '0;

    chime_sequencer #(
        .TONE_LEN(16'd8),
        .GAP_LEN (16'd4),
        .A_HALF  (16'd2),
        .B_HALF  (16'd3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .play  (play),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Expected outputs in cycle N+k, where the start edge was sampled at edge N.
    function automatic outs_t exp_at(input int k);
        outs_t      o;
        logic [7:0] apat;
        logic [7:0] bpat;
        apat = 8'b11001100;
        bpat = 8'b00111000;
        o = '0;
        if (k >= 1 && k <= 20) o.busy = 1'b1;
        if (k >= 1 && k <= 8) begin
            o.play = 1'b1;
            o.a    = apat[k-1];
        end
        if (k >= 13 && k <= 20) begin
            o.play = 1'b1;
            o.sel  = 1'b1;
            o.b    = bpat[k-13];
        end
        if (k == 21) o.done = 1'b1;
        return o;
    endfunction

    function automatic outs_t actual();
        outs_t o;
        o = '{busy: busy, play: play, sel: sel, a: a, b: b, done: done};
        return o;
    endfunction

    task automatic check_out();
        outs_t e;
        outs_t got;
        string nm;
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = actual();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got busy/play/sel/a/b/done=%b, expected %b", nm, got, e);
        end
    endtask

    task automatic drive(input logic btn, input logic rs, input outs_t e, input string nm);
        @(negedge clk);
        button = btn;
        rst    = rs;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int j = 0; j < 24; j++) begin
            tbl[j].button = (j < 3);
            tbl[j].exp    = exp_at(j + 1);
        end

        // Reset state
        for (int j = 0; j < 3; j++) drive(1'b0, 1'b1, IDLE_O, "reset");
        for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, IDLE_O, "idle_after_reset");

        // Single press from the vector table
        for (int j = 0; j < 24; j++) drive(tbl[j].button, 1'b0, tbl[j].exp, $sformatf("single_k%0d", j + 1));
        for (int j = 0; j < 2; j++) drive(1'b0, 1'b0, IDLE_O, "idle");

        // Second rising edge at N+5 is ignored
        for (int j = 0; j < 24; j++)
            drive((j < 2) || (j >= 5 && j < 8), 1'b0, exp_at(j + 1), $sformatf("ignored_k%0d", j + 1));

        // Held button: one sequence only, then a re-press starts another
        for (int j = 0; j < 40; j++) drive(1'b1, 1'b0, exp_at(j + 1), $sformatf("held_k%0d", j + 1));
        for (int j = 0; j < 2; j++) drive(1'b0, 1'b0, IDLE_O, "released");
        for (int j = 0; j < 22; j++) drive(j < 3, 1'b0, exp_at(j + 1), $sformatf("repress_k%0d", j + 1));

        // Back-to-back: new edge sampled on the done cycle
        for (int j = 0; j < 21; j++) drive(j < 3, 1'b0, exp_at(j + 1), $sformatf("b2b1_k%0d", j + 1));
        for (int j = 0; j < 23; j++) drive(j < 3, 1'b0, exp_at(j + 1), $sformatf("b2b2_k%0d", j + 1));

        // Reset mid-DONG: asserted asynchronously during cycle N+15
        for (int j = 0; j < 14; j++) drive(j < 3, 1'b0, exp_at(j + 1), $sformatf("rstseq_k%0d", j + 1));
        drive(1'b0, 1'b0, exp_at(15), "rstseq_k15");
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(IDLE_O);
        name_q.push_back("async_reset");
        check_out();
        drive(1'b0, 1'b1, IDLE_O, "reset_held");
        for (int j = 0; j < 25; j++) drive(1'b0, 1'b0, IDLE_O, "no_done_after_reset");

        // Button high through reset counts as a rising edge on release
        for (int j = 0; j < 2; j++) drive(1'b1, 1'b1, IDLE_O, "reset_button_high");
        for (int j = 0; j < 24; j++) drive(1'b1, 1'b0, exp_at(j + 1), $sformatf("post_reset_k%0d", j + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
